// File: rtl/seg_pipe_adder.sv
// Segment-pipelined add/subtract unit: one SEG-bit slice per stage, carries registered between stages.
// Define SEG_PIPE_ADDER_OVF_EN to add the signed-overflow output port ovf.
module seg_pipe_adder #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SEG_PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSEG = WIDTH / SEG;

    generate
        if (WIDTH % SEG != 0) begin : g_bad_cfg
            $error("seg_pipe_adder: WIDTH must be a multiple of SEG");
        end
    endgenerate

    logic             w_en;
    logic [WIDTH-1:0] w_beff;
    logic             w_c0;
    logic [SEG-1:0]   w_opa [NSEG];
    logic [SEG-1:0]   w_opb [NSEG];
    logic             w_ci  [NSEG];
    logic [SEG:0]     w_add [NSEG];
    logic             r_v   [NSEG];
    logic             r_c   [NSEG];
    logic [WIDTH-1:0] r_d   [NSEG];

    // One enable for the whole pipe: a held output freezes every stage, bubbles included.
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;
    assign w_beff   = sub ? ~b : b;
    assign w_c0     = sub | cin;

    assign w_opa[0] = a[SEG-1:0];
    assign w_opb[0] = w_beff[SEG-1:0];
    assign w_ci[0]  = w_c0;

    genvar k;
    generate
        for (k = 0; k < NSEG; k++) begin : g_add
            assign w_add[k] = {1'b0, w_opa[k]} + {1'b0, w_opb[k]} + {{SEG{1'b0}}, w_ci[k]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v[0] <= 1'b0;
            r_c[0] <= 1'b0;
        end else if (w_en) begin
            r_v[0] <= in_valid;
            r_c[0] <= w_add[0][SEG];
        end
    end

    generate
        if (NSEG == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_d[0] <= '0;
                end else if (w_en) begin
                    r_d[0] <= w_add[0][SEG-1:0];
                end
            end
        end else begin : g_multi
            // r_d rotates: finished sum slices enter at the top while unused A slices
            // drain out of the bottom, so slice k of A reaches stage k after k cycles
            // and all result slices of a beat line up in the last stage.
            logic [WIDTH-SEG-1:0] r_b [NSEG-1];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_d[0] <= '0;
                    r_b[0] <= '0;
                end else if (w_en) begin
                    r_d[0] <= {w_add[0][SEG-1:0], a[WIDTH-1:SEG]};
                    r_b[0] <= w_beff[WIDTH-1:SEG];
                end
            end

            for (k = 1; k < NSEG; k++) begin : g_stage
                assign w_opa[k] = r_d[k-1][SEG-1:0];
                assign w_opb[k] = r_b[k-1][SEG-1:0];
                assign w_ci[k]  = r_c[k-1];

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_v[k] <= 1'b0;
                        r_c[k] <= 1'b0;
                        r_d[k] <= '0;
                    end else if (w_en) begin
                        r_v[k] <= r_v[k-1];
                        r_c[k] <= w_add[k][SEG];
                        r_d[k] <= {w_add[k][SEG-1:0], r_d[k-1][WIDTH-1:SEG]};
                    end
                end
            end

            for (k = 1; k < NSEG - 1; k++) begin : g_bskew
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_b[k] <= '0;
                    end else if (w_en) begin
                        r_b[k] <= r_b[k-1] >> SEG;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = r_v[NSEG-1];
    assign sum       = r_d[NSEG-1];
    assign cout      = r_c[NSEG-1];

`ifdef SEG_PIPE_ADDER_OVF_EN
    // The top slice is computed in the last stage, so its sign bits are on hand there.
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_ovf <= (w_opa[NSEG-1][SEG-1] == w_opb[NSEG-1][SEG-1]) &&
                     (w_add[NSEG-1][SEG-1] != w_opa[NSEG-1][SEG-1]);
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
